// File: rtl/sevenseg_pkg.sv
// Segment encodings and the digit decode shared by the 7-segment scan driver.
// Bit 6 is segment a, bit 0 is segment g; a 1 lights the segment.
package sevenseg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'b1111110;
   localparam seg_t SEG_1     = 7'b0110000;
   localparam seg_t SEG_2     = 7'b1101101;
   localparam seg_t SEG_3     = 7'b1111001;
   localparam seg_t SEG_4     = 7'b0110011;
   localparam seg_t SEG_5     = 7'b1011011;
   localparam seg_t SEG_6     = 7'b1011111;
   localparam seg_t SEG_7     = 7'b1110000;
   localparam seg_t SEG_8     = 7'b1111111;
   localparam seg_t SEG_9     = 7'b1110011;
   localparam seg_t SEG_A     = 7'b1110111;
   localparam seg_t SEG_B     = 7'b0011111;
   localparam seg_t SEG_C     = 7'b1001110;
   localparam seg_t SEG_D     = 7'b0111101;
   localparam seg_t SEG_E     = 7'b1001111;
   localparam seg_t SEG_F     = 7'b1000111;
   localparam seg_t SEG_BLANK = 7'b0000000;

   // Codes 10-15 only light up when hex display is enabled.
   function automatic seg_t seg_decode(input logic [3:0] code, input bit hex);
      seg_t seg;
      case (code)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = hex ? SEG_A : SEG_BLANK;
         4'hB:    seg = hex ? SEG_B : SEG_BLANK;
         4'hC:    seg = hex ? SEG_C : SEG_BLANK;
         4'hD:    seg = hex ? SEG_D : SEG_BLANK;
         4'hE:    seg = hex ? SEG_E : SEG_BLANK;
         default: seg = hex ? SEG_F : SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational digit decoder: one 4-bit code in, abcdefg segment pattern out.
module sevenseg_decode
   import sevenseg_pkg::*;
#(
   parameter bit HEX_MODE = 1'b0
) (
   input  logic [3:0] i_code,
   output seg_t       o_seg
);

   assign o_seg = seg_decode(i_code, HEX_MODE);

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed 7-segment driver: prescaled digit scan, double-buffered frame
// content, leading-zero blanking and registered (optionally inverted) pin outputs.
module sevenseg_scan
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 1000,
   parameter bit HEX_MODE   = 1'b0,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_tick
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        r_slot;
   logic [IDX_W-1:0]        r_idx;
   logic [4*NUM_DIGITS-1:0] r_pend_val;
   logic [NUM_DIGITS-1:0]   r_pend_dp;
   logic [4*NUM_DIGITS-1:0] r_disp_val;
   logic [NUM_DIGITS-1:0]   r_disp_dp;
   seg_t                    r_seg;
   logic                    r_dp;
   logic [NUM_DIGITS-1:0]   r_sel;
   logic                    r_tick;

   logic                    w_slot_wrap;
   logic                    w_frame_wrap;
   logic [3:0]              w_code;
   logic                    w_dp;
   logic                    w_blank;
   logic                    w_zero_run;
   logic [NUM_DIGITS-1:0]   w_sel;
   seg_t                    w_dec;
   seg_t                    w_seg;

   assign w_slot_wrap  = (r_slot == SLOT_LAST);
   assign w_frame_wrap = w_slot_wrap && (r_idx == IDX_LAST);

   // Walk from the top digit down so the zero run covers "this digit and all above".
   always_comb begin
      w_code     = 4'h0;
      w_dp       = 1'b0;
      w_blank    = 1'b0;
      w_zero_run = 1'b1;
      w_sel      = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         w_zero_run = w_zero_run && (r_disp_val[k*4 +: 4] == 4'h0);
         w_sel[k]   = (r_idx == IDX_W'(k));
         if (w_sel[k]) begin
            w_code  = r_disp_val[k*4 +: 4];
            w_dp    = r_disp_dp[k];
            w_blank = blank_lz && w_zero_run && (k != 0);
         end
      end
   end

   sevenseg_decode #(
      .HEX_MODE (HEX_MODE)
   ) u_decode (
      .i_code (w_code),
      .o_seg  (w_dec)
   );

   assign w_seg = w_blank ? SEG_BLANK : w_dec;

   // Display content only changes on the frame boundary, so a frame never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot     <= '0;
         r_idx      <= '0;
         r_pend_val <= '0;
         r_pend_dp  <= '0;
         r_disp_val <= '0;
         r_disp_dp  <= '0;
         r_seg      <= SEG_BLANK;
         r_dp       <= 1'b0;
         r_sel      <= '0;
         r_tick     <= 1'b0;
      end else begin
         r_slot <= w_slot_wrap ? '0 : r_slot + 1'b1;
         if (w_slot_wrap) begin
            r_idx <= w_frame_wrap ? '0 : r_idx + 1'b1;
         end
         if (load) begin
            r_pend_val <= value;
            r_pend_dp  <= dp_in;
         end
         if (w_frame_wrap) begin
            r_disp_val <= r_pend_val;
            r_disp_dp  <= r_pend_dp;
         end
         r_seg  <= w_seg;
         r_dp   <= w_dp;
         r_sel  <= w_sel;
         r_tick <= (r_slot == '0) && (r_idx == '0);
      end
   end

   assign seg_out    = r_seg ^ {7{ACTIVE_LOW}};
   assign dp_out     = r_dp ^ ACTIVE_LOW;
   assign digit_sel  = r_sel ^ {NUM_DIGITS{ACTIVE_LOW}};
   assign frame_tick = r_tick;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan: three instances (plain, hex, active-low)
// share one stimulus stream and are checked every cycle of selected frames.
module tb_sevenseg_scan;

   localparam logic [6:0] Z  = 7'b0000000;
   localparam logic [6:0] S0 = 7'b1111110;
   localparam logic [6:0] S1 = 7'b0110000;
   localparam logic [6:0] S2 = 7'b1101101;
   localparam logic [6:0] S3 = 7'b1111001;
   localparam logic [6:0] S4 = 7'b0110011;
   localparam logic [6:0] S7 = 7'b1110000;
   localparam logic [6:0] S8 = 7'b1111111;
   localparam logic [6:0] SA = 7'b1110111;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        blank_lz;

   logic [6:0]  seg_m, seg_h, seg_a;
   logic        dp_m, dp_h, dp_a;
   logic [3:0]  sel_m, sel_h, sel_a;
   logic        tick_m, tick_h, tick_a;

   int total;
   int bad;

   sevenseg_scan #(.NUM_DIGITS(4), .PRESCALE(4), .HEX_MODE(1'b0), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg_out(seg_m), .dp_out(dp_m), .digit_sel(sel_m),
      .frame_tick(tick_m));

   sevenseg_scan #(.NUM_DIGITS(4), .PRESCALE(4), .HEX_MODE(1'b1), .ACTIVE_LOW(1'b0)) dut_hex (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg_out(seg_h), .dp_out(dp_h), .digit_sel(sel_h),
      .frame_tick(tick_h));

   sevenseg_scan #(.NUM_DIGITS(4), .PRESCALE(4), .HEX_MODE(1'b0), .ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg_out(seg_a), .dp_out(dp_a), .digit_sel(sel_a),
      .frame_tick(tick_a));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_sel"},   32'(sel_m),  32'h0);
      chk({tag, "_seg"},   32'(seg_m),  32'h0);
      chk({tag, "_dp"},    32'(dp_m),   32'h0);
      chk({tag, "_tick"},  32'(tick_m), 32'h0);
      chk({tag, "_hsel"},  32'(sel_h),  32'h0);
      chk({tag, "_asel"},  32'(sel_a),  32'hF);
      chk({tag, "_aseg"},  32'(seg_a),  32'h7F);
      chk({tag, "_adp"},   32'(dp_a),   32'h1);
      chk({tag, "_atick"}, 32'(tick_a), 32'h0);
   endtask

   // segs/hsegs pack digit k at [k*7 +: 7]; load_at (0..14) pulses load in that frame cycle.
   task automatic check_frame(input string tag, input logic [27:0] segs,
                              input logic [27:0] hsegs, input logic [3:0] dps,
                              input bit contig, input int load_at,
                              input logic [15:0] ld_val, input logic [3:0] ld_dp);
      bit found;
      int k;
      found = 1'b0;
      if (contig) begin
         @(negedge clk);
         found = 1'b1;
      end else begin
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tick_m === 1'b1) begin
               found = 1'b1;
               break;
            end
         end
      end
      if (!found) begin
         chk({tag, "_tick_timeout"}, 32'h0, 32'h1);
         return;
      end
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge clk);
         load = 1'b0;
         if (c == load_at) begin
            load  = 1'b1;
            value = ld_val;
            dp_in = ld_dp;
         end
         k = c / 4;
         chk($sformatf("%s_c%0d_sel", tag, c),   32'(sel_m),  32'(4'b0001 << k));
         chk($sformatf("%s_c%0d_seg", tag, c),   32'(seg_m),  32'(segs[k*7 +: 7]));
         chk($sformatf("%s_c%0d_dp", tag, c),    32'(dp_m),   32'(dps[k]));
         chk($sformatf("%s_c%0d_tick", tag, c),  32'(tick_m), 32'(c == 0));
         chk($sformatf("%s_c%0d_hseg", tag, c),  32'(seg_h),  32'(hsegs[k*7 +: 7]));
         chk($sformatf("%s_c%0d_asel", tag, c),  32'(sel_a),  32'(~(4'b0001 << k) & 4'hF));
         chk($sformatf("%s_c%0d_aseg", tag, c),  32'(seg_a),  32'(~segs[k*7 +: 7] & 7'h7F));
         chk($sformatf("%s_c%0d_adp", tag, c),   32'(dp_a),   32'(~dps[k] & 1'b1));
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst_n    = 1'b1;
      load     = 1'b0;
      value    = 16'h0;
      dp_in    = 4'h0;
      blank_lz = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;

      // First frame shows zero; load 1234 mid-frame.
      check_frame("f0_zero", {S0, S0, S0, S0}, {S0, S0, S0, S0}, 4'b0000, 1'b0, 5, 16'h1234, 4'h0);
      check_frame("f1_1234", {S1, S2, S3, S4}, {S1, S2, S3, S4}, 4'b0000, 1'b1, 5, 16'h0070, 4'h0);
      blank_lz = 1'b1;
      check_frame("f2_lz_on", {Z, Z, S7, S0}, {Z, Z, S7, S0}, 4'b0000, 1'b1, -1, 16'h0, 4'h0);
      blank_lz = 1'b0;
      // Load in the digit 2 slot; the current frame must stay unchanged.
      check_frame("f3_lz_off", {S0, S0, S7, S0}, {S0, S0, S7, S0}, 4'b0000, 1'b1, 9, 16'h000A, 4'b0001);
      blank_lz = 1'b1;
      check_frame("f4_hex_dp", {Z, Z, Z, Z}, {Z, Z, Z, SA}, 4'b0001, 1'b1, 9, 16'h1111, 4'h0);
      // Load in the boundary cycle: visible only one frame later.
      check_frame("f5_1111", {S1, S1, S1, S1}, {S1, S1, S1, S1}, 4'b0000, 1'b1, 14, 16'h0008, 4'h0);
      check_frame("f6_hold", {S1, S1, S1, S1}, {S1, S1, S1, S1}, 4'b0000, 1'b1, -1, 16'h0, 4'h0);
      check_frame("f7_0008", {Z, Z, Z, S8}, {Z, Z, Z, S8}, 4'b0000, 1'b1, -1, 16'h0, 4'h0);

      // Reset mid-slot must clear outputs without waiting for a clock edge.
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset("midreset_async");
      @(negedge clk);
      chk_reset("midreset_held");
      rst_n = 1'b1;
      check_frame("f8_after_rst", {Z, Z, Z, S0}, {Z, Z, Z, S0}, 4'b0000, 1'b0, -1, 16'h0, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
